// File: rtl/uart_avalon_driver.sv
// Avalon-MM master for the RS232 core: pushes a TX byte stream into the DATA register,
// polls DATA for received bytes, and caches the core's TX space from CONTROL.
module uart_avalon_driver #(
  parameter int unsigned POLL_INTERVAL = 16,
  parameter int unsigned PCW           = 8
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  output logic        av_address,
  output logic        av_chipselect,
  output logic [3:0]  av_byteenable,
  output logic        av_read,
  output logic        av_write,
  output logic [31:0] av_writedata,
  input  logic [31:0] av_readdata,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_TXW, S_CRD, S_CCAP, S_DRD, S_DCAP
  } state_e;

  localparam logic TURN_TX = 1'b0;

  state_e          state_q, state_d;
  logic            turn_q, turn_d;
  logic [15:0]     wspace_q, wspace_d;
  logic [PCW-1:0]  tx_wait_q, tx_wait_d;
  logic [PCW-1:0]  rx_wait_q, rx_wait_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            av_address_q, av_address_d;
  logic            av_chipselect_q, av_chipselect_d;
  logic [3:0]      av_byteenable_q, av_byteenable_d;
  logic            av_read_q, av_read_d;
  logic            av_write_q, av_write_d;
  logic [31:0]     av_writedata_q, av_writedata_d;
  logic            tx_ready_q, tx_ready_d;
  logic            tx_elig, rx_elig;
  logic [6:0]      unused_rd_bits;

  assign unused_rd_bits = av_readdata[14:8];

  // State register
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) state_q <= S_INIT;
    else                state_q <= state_d;
  end

  // Next state and TX/RX arbitration; the init write is issued once, then idle
  always_comb begin
    state_d = state_q;
    turn_d  = turn_q;
    tx_elig = tx_valid && (tx_wait_q == '0);
    rx_elig = !rx_valid_q && (rx_wait_q == '0);
    case (state_q)
      S_INIT: if (av_write_q) state_d = S_IDLE;
      S_IDLE: begin
        if (tx_elig && ((turn_q == TURN_TX) || !rx_elig)) begin
          state_d = (wspace_q != 16'h0) ? S_TXW : S_CRD;
          turn_d  = ~turn_q;
        end else if (rx_elig) begin
          state_d = S_DRD;
          turn_d  = ~turn_q;
        end
      end
      S_TXW:   state_d = S_IDLE;
      S_CRD:   state_d = S_CCAP;
      S_CCAP:  state_d = S_IDLE;
      S_DRD:   state_d = S_DCAP;
      S_DCAP:  state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  // Bus outputs decoded from the state being entered, so they register in step with it
  always_comb begin
    av_address_d   = 1'b0;
    av_read_d      = 1'b0;
    av_write_d     = 1'b0;
    av_writedata_d = 32'h0;
    tx_ready_d     = 1'b0;
    case (state_d)
      S_INIT: begin
        av_write_d   = 1'b1;
        av_address_d = 1'b1;
      end
      S_TXW: begin
        av_write_d     = 1'b1;
        av_writedata_d = {24'h0, tx_data};
        tx_ready_d     = 1'b1;
      end
      S_CRD: begin
        av_read_d    = 1'b1;
        av_address_d = 1'b1;
      end
      S_DRD:   av_read_d = 1'b1;
      default: ;
    endcase
    av_chipselect_d = av_read_d | av_write_d;
    av_byteenable_d = av_chipselect_d ? 4'hF : 4'h0;
  end

  // Space cache, poll back-off counters and the one-byte RX skid
  always_comb begin
    wspace_d   = wspace_q;
    tx_wait_d  = (tx_wait_q != '0) ? tx_wait_q - PCW'(1) : '0;
    rx_wait_d  = (rx_wait_q != '0) ? rx_wait_q - PCW'(1) : '0;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q && !rx_ready;
    case (state_q)
      S_TXW: if (wspace_q != 16'h0) wspace_d = wspace_q - 16'd1;
      S_CCAP: begin
        wspace_d = av_readdata[31:16];
        if (av_readdata[31:16] == 16'h0) tx_wait_d = PCW'(POLL_INTERVAL);
      end
      S_DCAP: begin
        if (av_readdata[15]) begin
          rx_data_d  = av_readdata[7:0];
          rx_valid_d = 1'b1;
        end else begin
          rx_wait_d = PCW'(POLL_INTERVAL);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      turn_q          <= TURN_TX;
      wspace_q        <= 16'h0;
      tx_wait_q       <= '0;
      rx_wait_q       <= '0;
      rx_data_q       <= 8'h0;
      rx_valid_q      <= 1'b0;
      av_address_q    <= 1'b0;
      av_chipselect_q <= 1'b0;
      av_byteenable_q <= 4'h0;
      av_read_q       <= 1'b0;
      av_write_q      <= 1'b0;
      av_writedata_q  <= 32'h0;
      tx_ready_q      <= 1'b0;
    end else begin
      turn_q          <= turn_d;
      wspace_q        <= wspace_d;
      tx_wait_q       <= tx_wait_d;
      rx_wait_q       <= rx_wait_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      av_address_q    <= av_address_d;
      av_chipselect_q <= av_chipselect_d;
      av_byteenable_q <= av_byteenable_d;
      av_read_q       <= av_read_d;
      av_write_q      <= av_write_d;
      av_writedata_q  <= av_writedata_d;
      tx_ready_q      <= tx_ready_d;
    end
  end

  assign av_address    = av_address_q;
  assign av_chipselect = av_chipselect_q;
  assign av_byteenable = av_byteenable_q;
  assign av_read       = av_read_q;
  assign av_write      = av_write_q;
  assign av_writedata  = av_writedata_q;
  assign tx_ready      = tx_ready_q;
  assign rx_data       = rx_data_q;
  assign rx_valid      = rx_valid_q;

endmodule
